// File: rtl/pipe_ctrl.sv
// Pipeline stall/flush scheduler: arbitrates jump redirects, load-use hazards, multi-cycle
// EX ops and bus wait into per-bank hold/flush enables plus a saturating stall counter.
`ifndef WORD_WIDTH
`define WORD_WIDTH 32
`endif

module pipe_ctrl #(
    parameter int unsigned WIDTH = `WORD_WIDTH,
    parameter int unsigned CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             jump_req,
    input  logic [WIDTH-1:0] jump_addr,
    input  logic             ld_use_hazard,
    input  logic             mc_start,
    input  logic [CNT_W-1:0] mc_cycles,
    input  logic             bus_hold,
    input  logic             stall_clr,
    output logic             pc_hold,
    output logic             pc_load,
    output logic [WIDTH-1:0] pc_load_addr,
    output logic             if_id_hold,
    output logic             if_id_flush,
    output logic             id_ex_hold,
    output logic             id_ex_flush,
    output logic             ex_wb_hold,
    output logic             ex_wb_flush,
    output logic [1:0]       ctrl_state,
    output logic [WIDTH-1:0] stall_cycles
);

    typedef enum logic [1:0] {
        StInit = 2'd0,
        StRun  = 2'd1,
        StMc   = 2'd2,
        StHold = 2'd3
    } state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   mc_cnt_q, mc_cnt_d;
    logic               jump_pend_q, jump_pend_d;
    logic [WIDTH-1:0]   pend_addr_q, pend_addr_d;
    logic [WIDTH-1:0]   stall_q, stall_d;

    always_comb begin
        pc_hold      = 1'b0;
        pc_load      = 1'b0;
        pc_load_addr = '0;
        if_id_hold   = 1'b0;
        if_id_flush  = 1'b0;
        id_ex_hold   = 1'b0;
        id_ex_flush  = 1'b0;
        ex_wb_hold   = 1'b0;
        ex_wb_flush  = 1'b0;
        state_d      = state_q;
        mc_cnt_d     = mc_cnt_q;
        jump_pend_d  = jump_pend_q;
        pend_addr_d  = pend_addr_q;

        unique case (state_q)
            StInit: begin
                pc_hold     = 1'b1;
                if_id_flush = 1'b1;
                id_ex_flush = 1'b1;
                ex_wb_flush = 1'b1;
                state_d     = StRun;
            end
            StMc: begin
                pc_hold    = 1'b1;
                if_id_hold = 1'b1;
                id_ex_hold = 1'b1;
                if (bus_hold) begin
                    ex_wb_hold = 1'b1;
                end else begin
                    ex_wb_flush = 1'b1;
                    if (mc_cnt_q == '0) begin
                        state_d = StRun;
                    end else begin
                        mc_cnt_d = mc_cnt_q - CNT_W'(1);
                    end
                end
            end
            // HOLD with bus_hold released falls through the RUN priority in the same cycle.
            StRun, StHold: begin
                if (bus_hold) begin
                    pc_hold    = 1'b1;
                    if_id_hold = 1'b1;
                    id_ex_hold = 1'b1;
                    ex_wb_hold = 1'b1;
                    state_d    = StHold;
                    if (jump_req) begin
                        jump_pend_d = 1'b1;
                        pend_addr_d = jump_addr;
                    end
                end else if (jump_req || jump_pend_q) begin
                    pc_load      = 1'b1;
                    pc_load_addr = jump_pend_q ? pend_addr_q : jump_addr;
                    if_id_flush  = 1'b1;
                    id_ex_flush  = 1'b1;
                    jump_pend_d  = 1'b0;
                    state_d      = StRun;
                end else if (mc_start && (mc_cycles != '0)) begin
                    pc_hold     = 1'b1;
                    if_id_hold  = 1'b1;
                    id_ex_hold  = 1'b1;
                    ex_wb_flush = 1'b1;
                    if (mc_cycles == CNT_W'(1)) begin
                        state_d = StRun;
                    end else begin
                        mc_cnt_d = mc_cycles - CNT_W'(2);
                        state_d  = StMc;
                    end
                end else begin
                    state_d = StRun;
                    if (ld_use_hazard) begin
                        pc_hold     = 1'b1;
                        if_id_hold  = 1'b1;
                        id_ex_flush = 1'b1;
                    end
                end
            end
            default: state_d = StInit;
        endcase
    end

    always_comb begin
        stall_d = stall_q;
        if (stall_clr) begin
            stall_d = '0;
        end else if (pc_hold && (state_q != StInit) && (stall_q != '1)) begin
            stall_d = stall_q + WIDTH'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StInit;
            mc_cnt_q    <= '0;
            jump_pend_q <= 1'b0;
            pend_addr_q <= '0;
            stall_q     <= '0;
        end else begin
            state_q     <= state_d;
            mc_cnt_q    <= mc_cnt_d;
            jump_pend_q <= jump_pend_d;
            pend_addr_q <= pend_addr_d;
            stall_q     <= stall_d;
        end
    end

    assign ctrl_state   = state_q;
    assign stall_cycles = stall_q;

endmodule

// File: doc/pipe_ctrl.md
Name: pipe_ctrl

Overview:
Central stall/flush scheduler for the core's pipeline registers (IF/ID, ID/EX, EX/WB banks built from the team's WIDTH-bit DFF stages).
It arbitrates jump redirects, load-use hazards, multi-cycle EX operations and external bus wait. Per cycle it produces hold/flush enables for each register bank plus PC write control.
It also keeps a saturating stall-cycle performance counter.

Parameters:
WIDTH, `WORD_WIDTH (32), address/counter width
CNT_W, 4, width of multi-cycle stall count

Ports:
clk  in  1  clock
rst_n  in  1  reset
jump_req  in  1  EX-stage redirect request
jump_addr  in  WIDTH  redirect target
ld_use_hazard  in  1  ID-stage load-use detected
mc_start  in  1  EX starts multi-cycle op (mul/div)
mc_cycles  in  CNT_W  total stall cycles K for that op
bus_hold  in  1  memory bus wait, freeze pipeline
stall_clr  in  1  synchronous clear of stall_cycles
pc_hold  out  1  PC register hold
pc_load  out  1  PC loads pc_load_addr
pc_load_addr  out  WIDTH  redirect target to PC
if_id_hold  out  1  IF/ID hold
if_id_flush  out  1  IF/ID clear to bubble
id_ex_hold  out  1  ID/EX hold
id_ex_flush  out  1  ID/EX clear to bubble
ex_wb_hold  out  1  EX/WB hold
ex_wb_flush  out  1  EX/WB clear to bubble
ctrl_state  out  2  INIT=0, RUN=1, MC=2, HOLD=3
stall_cycles  out  WIDTH  saturating stall counter

Behaviour:
- Reset: rst_n, asynchronous, active-low; clock clk.
- Registered state: state, mc_cnt, jump_pend, pend_addr, stall_cycles. Reset values: INIT, 0, 0, 0, 0.
- All control outputs are combinational from registered state plus current inputs (0-cycle latency).
- Output values:
  - In INIT (including while rst_n low): pc_hold=1, all three flushes=1, all other holds=0, pc_load=0, pc_load_addr=0.
  - Anything not driven by a rule below is 0.
- INIT: lasts exactly one clk after reset release, then RUN. All inputs are ignored in INIT.
- RUN priority, highest first. For the jump rule, effective jump = jump_req|jump_pend; effective addr = jump_pend ? pend_addr : jump_addr.
  1. bus_hold=1:
     - pc_hold, if_id_hold, id_ex_hold, ex_wb_hold all =1; no flushes; next state HOLD.
     - If jump_req=1, latch jump_pend=1 and pend_addr=jump_addr.
  2. Effective jump:
     - pc_load=1, pc_load_addr=effective addr, if_id_flush=1, id_ex_flush=1.
     - Clear jump_pend.
     - mc_start and ld_use_hazard are ignored that cycle.
  3. mc_start=1 with K=mc_cycles:
     - K=0: no effect.
     - K>=1: pc_hold, if_id_hold, id_ex_hold=1 and ex_wb_flush=1 this cycle.
     - K=1: stay RUN.
     - K>=2: mc_cnt<=K-2, next MC.
  4. ld_use_hazard=1: pc_hold=1, if_id_hold=1, id_ex_flush=1, for one cycle per asserted cycle.
- MC:
  - Outputs: pc_hold, if_id_hold, id_ex_hold=1 every cycle.
  - If bus_hold=0: ex_wb_flush=1. If mc_cnt==0, next RUN; else mc_cnt decrements.
  - If bus_hold=1: ex_wb_hold=1 instead of ex_wb_flush, and mc_cnt is frozen.
  - Total stall for an op = exactly K cycles plus any bus_hold cycles.
  - jump_req, mc_start and ld_use_hazard are ignored in MC.
- HOLD:
  - bus_hold=1: all four holds =1. jump_req still latches pend (idempotent).
  - bus_hold=0: evaluate RUN priority in the same cycle, so a pending jump issues on the release cycle; the next state follows the RUN rules.
- stall_cycles:
  - stall_clr=1 clears it to 0 (has priority).
  - Otherwise it increments by 1 on each cycle with pc_hold=1 in RUN/MC/HOLD.
  - INIT cycles are not counted. It saturates at all-ones.
- Reset mid-operation: immediate INIT outputs; pending jump and mc_cnt are discarded.

Test Plan:
1. Release rst_n -> for one cycle: ctrl_state=0, pc_hold=1, if_id_flush=id_ex_flush=ex_wb_flush=1. Next cycle: ctrl_state=1, all outputs 0, stall_cycles=0.
2. RUN, jump_req=1 with jump_addr=0x00000100 -> same cycle: pc_load=1, pc_load_addr=0x100, if_id_flush=id_ex_flush=1. Next cycle all 0; stall_cycles unchanged.
3. mc_start with mc_cycles=4 -> pc_hold/if_id_hold/id_ex_hold/ex_wb_flush high exactly 4 cycles; ctrl_state=2 on cycles 2-4; stall_cycles+=4. mc_cycles=1 -> 1 cycle, state stays 1. mc_cycles=0 -> no stall.
4. bus_hold for 3 cycles, jump_req=1 addr 0x80 in the first -> all four holds high 3 cycles, pc_load=0. Release cycle: pc_load=1, addr=0x80, if_id_flush=id_ex_flush=1. Then state RUN, jump_pend=0.
5. ld_use_hazard alone -> one cycle pc_hold=if_id_hold=id_ex_flush=1. ld_use_hazard+jump_req same cycle -> only the jump outputs, if_id_hold=0. bus_hold mid-MC (K=5) -> ex_wb_hold=1 and ex_wb_flush=0 while held; total stall 5+hold cycles.
6. rst_n low during MC with mc_cnt=3 and jump_pend=1 -> INIT outputs immediately. After release: INIT one cycle, then RUN with no pc_load and no residual stall. stall_clr -> stall_cycles=0 next cycle.
